hazard_issue_ctrl: RTL and testbench

- Sequences the front half of the 5-stage RV32I pipeline.
- Owns the IF/ID register: instruction, PC and valid.
- Classifies the ID instruction by opcode, using the same opcode classes the immediate generator decodes.
- Detects load-use hazards, freezes the pipe on data-memory wait, and flushes on a taken branch or jump resolved in EX.
- Drives PC enable, IF/ID capture and ID/EX bubble insertion.

---
 rtl/hazard_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_issue_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_issue_ctrl.sv
// Front-half sequencer for the 5-stage RV32I pipe: owns IF/ID, classifies the ID opcode, resolves hazards.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic            ex_redirect,
    input  logic            dmem_busy,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic            id_valid,
    output logic [2:0]      id_opclass,
    output logic            pc_write,
    output logic            idex_bubble,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
`endif
    output logic            pipe_hold
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_id_inst;
    logic [XLEN-1:0] r_id_pc;
    logic            r_id_valid;

    logic [6:0] w_op;
    logic [2:0] w_cls;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_rs1_used;
    logic       w_rs2_used;
    logic       w_load_use;
    logic       w_lu_stall;
    logic       w_capture;

    assign w_op  = r_id_inst[6:0];
    assign w_rs1 = r_id_inst[19:15];
    assign w_rs2 = r_id_inst[24:20];

    always_comb begin
        w_cls = 3'd0;
        case (w_op)
            7'b0110011:             w_cls = 3'd1;
            7'b0010011:             w_cls = 3'd2;
            7'b0000011:             w_cls = 3'd3;
            7'b0100011:             w_cls = 3'd4;
            7'b1100011:             w_cls = 3'd5;
            7'b1101111, 7'b1100111: w_cls = 3'd6;
            7'b0110111, 7'b0010111: w_cls = 3'd7;
            default:                w_cls = 3'd0;
        endcase
    end

    // JAL has no source register; only JALR reads rs1 within the jump class.
    assign w_rs1_used = (w_cls >= 3'd1 && w_cls <= 3'd5) || (w_op == 7'b1100111);
    assign w_rs2_used = (w_cls == 3'd1) || (w_cls == 3'd4) || (w_cls == 3'd5);

    assign w_load_use = r_id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                        ((w_rs1_used && (w_rs1 == ex_rd)) || (w_rs2_used && (w_rs2 == ex_rd)));

    // The cycle after a load-use stall EX holds the bubble, so the hazard is not re-checked.
    assign w_lu_stall = w_load_use && (r_state != ST_LU_STALL);
    assign w_capture  = !ex_redirect && !dmem_busy && !w_lu_stall;

    always_comb begin
        pc_write    = 1'b1;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        if (ex_redirect) begin
            idex_bubble = 1'b1;
        end else if (dmem_busy) begin
            pc_write  = 1'b0;
            pipe_hold = 1'b1;
        end else if (w_lu_stall) begin
            pc_write    = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_id_inst  <= '0;
            r_id_pc    <= '0;
            r_id_valid <= 1'b0;
        end else if (ex_redirect) begin
            r_state    <= ST_FLUSH;
            r_id_valid <= 1'b0;
        end else if (dmem_busy) begin
            r_state <= ST_MEM_WAIT;
        end else if (w_lu_stall) begin
            r_state <= ST_LU_STALL;
        end else begin
            r_state    <= ST_RUN;
            r_id_inst  <= if_inst;
            r_id_pc    <= if_pc;
            r_id_valid <= 1'b1;
        end
    end

    assign id_inst    = r_id_inst;
    assign id_pc      = r_id_pc;
    assign id_valid   = r_id_valid;
    assign id_opclass = r_id_valid ? w_cls : 3'd0;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_cycles;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (!pc_write && (r_stall_cycles != {CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (ex_redirect && (r_flush_cycles != {CNT_W{1'b1}}))
                r_flush_cycles <= r_flush_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`endif

    logic w_unused;
    assign w_unused = (w_capture == 1'b0) & 1'b0;

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Self-checking bench for hazard_issue_ctrl: directed pipeline scenarios plus randomized traffic vs a rule-level model.
module tb_hazard_issue_ctrl;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LUI  = 32'h123452B7;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] if_inst, if_pc;
    logic        ex_mem_read, ex_redirect, dmem_busy;
    logic [4:0]  ex_rd;
    logic [31:0] id_inst, id_pc;
    logic        id_valid, pc_write, idex_bubble, pipe_hold;
    logic [2:0]  id_opclass;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles, flush_cycles;
`endif

    always #5 clk = ~clk;

    hazard_issue_ctrl dut (
        .clk(clk), .reset_n(reset_n), .if_inst(if_inst), .if_pc(if_pc),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
        .id_inst(id_inst), .id_pc(id_pc), .id_valid(id_valid), .id_opclass(id_opclass),
        .pc_write(pc_write), .idex_bubble(idex_bubble),
`ifdef HAZARD_PERF_EN
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
`endif
        .pipe_hold(pipe_hold)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the IF/ID contents plus "a load-use stall was just taken".
    logic [31:0] m_inst, m_pc;
    logic        m_valid, m_lu_last;
    logic        e_pcw, e_bub, e_hold, e_lu;
    logic [2:0]  e_cls;

    function automatic logic [2:0] classify(input logic [6:0] op);
        case (op)
            7'h33:        return 3'd1;
            7'h13:        return 3'd2;
            7'h03:        return 3'd3;
            7'h23:        return 3'd4;
            7'h63:        return 3'd5;
            7'h6F, 7'h67: return 3'd6;
            7'h37, 7'h17: return 3'd7;
            default:      return 3'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_inst = 0; m_pc = 0; m_valid = 0; m_lu_last = 0;
    endtask

    task automatic model_eval();
        logic [2:0] c;
        logic u1, u2;
        c  = classify(m_inst[6:0]);
        u1 = (c inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5}) || (m_inst[6:0] == 7'h67);
        u2 = (c inside {3'd1, 3'd4, 3'd5});
        e_cls = m_valid ? c : 3'd0;
        e_lu  = m_valid && ex_mem_read && (ex_rd != 0) && !m_lu_last &&
                ((u1 && m_inst[19:15] == ex_rd) || (u2 && m_inst[24:20] == ex_rd));
        if (ex_redirect)    begin e_pcw = 1; e_bub = 1; e_hold = 0; end
        else if (dmem_busy) begin e_pcw = 0; e_bub = 0; e_hold = 1; end
        else if (e_lu)      begin e_pcw = 0; e_bub = 1; e_hold = 0; end
        else                begin e_pcw = 1; e_bub = 0; e_hold = 0; end
    endtask

    task automatic model_update();
        if (ex_redirect)    begin m_valid = 0; m_lu_last = 0; end
        else if (dmem_busy) m_lu_last = 0;
        else if (e_lu)      m_lu_last = 1;
        else begin m_inst = if_inst; m_pc = if_pc; m_valid = 1; m_lu_last = 0; end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic mr,
                         input logic [4:0] rd, input logic redir, input logic busy);
        @(negedge clk);
        if_inst = inst; if_pc = pc; ex_mem_read = mr; ex_rd = rd; ex_redirect = redir; dmem_busy = busy;
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
    endtask

    task automatic test_reset();
        if_inst = 0; if_pc = 0; ex_mem_read = 0; ex_rd = 0; ex_redirect = 0; dmem_busy = 0;
        reset_n = 1'b0;
        #12;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
        checks++; if (id_inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", id_inst); end
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", id_pc); end
        checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL rst_pcw got=%b exp=1", pc_write); end
        checks++; if (idex_bubble !== 1'b0 || pipe_hold !== 1'b0) begin failures++; $display("FAIL rst_bub_hold got=%b%b exp=00", idex_bubble, pipe_hold); end
`ifdef HAZARD_PERF_EN
        checks++; if (stall_cycles !== 0 || flush_cycles !== 0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_cycles); end
`endif
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        drive(I_ADDI, 32'h0, 0, 0, 0, 0);
        advance();
        drive(I_ADD, 32'h4, 0, 0, 0, 0);
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", id_valid); end
        checks++; if (id_opclass !== 3'd2) begin failures++; $display("FAIL basic_cls got=%0d exp=2", id_opclass); end
        checks++; if (id_inst !== I_ADDI) begin failures++; $display("FAIL basic_inst got=%h exp=%h", id_inst, I_ADDI); end
        checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin failures++; $display("FAIL basic_pcw_bub got=%b%b exp=10", pc_write, idex_bubble); end
        advance();
    endtask

    task automatic test_load_use();
        drive(I_LUI, 32'h8, 1, 5'd1, 0, 0);
        checks++; if (pc_write !== 1'b0 || idex_bubble !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b%b exp=01", pc_write, idex_bubble); end
        advance();
        drive(I_LUI, 32'h8, 1, 5'd1, 0, 0);
        checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin failures++; $display("FAIL lu_once got=%b%b exp=10", pc_write, idex_bubble); end
        checks++; if (id_inst !== I_ADD) begin failures++; $display("FAIL lu_hold got=%h exp=%h", id_inst, I_ADD); end
        advance();
        drive(I_ADD, 32'hC, 1, 5'd5, 0, 0);
        checks++; if (id_inst !== I_LUI) begin failures++; $display("FAIL lu_advance got=%h exp=%h", id_inst, I_LUI); end
        checks++; if (id_opclass !== 3'd7) begin failures++; $display("FAIL upper_cls got=%0d exp=7", id_opclass); end
        checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin failures++; $display("FAIL upper_nostall got=%b%b exp=10", pc_write, idex_bubble); end
        advance();
        drive(I_ADDI, 32'h10, 1, 5'd0, 0, 0);
        checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin failures++; $display("FAIL x0_nostall got=%b%b exp=10", pc_write, idex_bubble); end
        advance();
    endtask

    task automatic test_redirect_busy();
        drive(I_ADD, 32'h14, 0, 0, 1, 1);
        checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b1 || pipe_hold !== 1'b0) begin failures++; $display("FAIL redir_out got=%b%b%b exp=110", pc_write, idex_bubble, pipe_hold); end
        advance();
        drive(I_ADDI, 32'h100, 0, 0, 0, 0);
        checks++; if (id_valid !== 1'b0 || id_opclass !== 3'd0) begin failures++; $display("FAIL flush_kill got=%b/%0d exp=0/0", id_valid, id_opclass); end
        advance();
        drive(I_ADD, 32'h104, 0, 0, 0, 0);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin failures++; $display("FAIL flush_refetch got=%b/%h exp=1/100", id_valid, id_pc); end
        advance();
    endtask

    task automatic test_busy();
`ifdef HAZARD_PERF_EN
        logic [15:0] snap;
        snap = stall_cycles;
`endif
        for (int i = 0; i < 3; i++) begin
            drive(I_LUI, 32'h108, 0, 0, 0, 1);
            checks++; if (pipe_hold !== 1'b1 || pc_write !== 1'b0) begin failures++; $display("FAIL busy_hold[%0d] got=%b%b exp=10", i, pipe_hold, pc_write); end
            checks++; if (id_inst !== I_ADD) begin failures++; $display("FAIL busy_inst[%0d] got=%h exp=%h", i, id_inst, I_ADD); end
            advance();
        end
        drive(I_LUI, 32'h108, 0, 0, 0, 0);
        checks++; if (pipe_hold !== 1'b0 || pc_write !== 1'b1) begin failures++; $display("FAIL busy_release got=%b%b exp=01", pipe_hold, pc_write); end
`ifdef HAZARD_PERF_EN
        checks++; if (stall_cycles !== snap + 16'd3) begin failures++; $display("FAIL perf_stall got=%0d exp=%0d", stall_cycles, snap + 16'd3); end
`endif
        advance();
    endtask

    task automatic test_reset_midstall();
        drive(I_ADD, 32'h200, 0, 0, 0, 0);
        advance();
        drive(I_ADDI, 32'h204, 1, 5'd2, 0, 0);
        checks++; if (pc_write !== 1'b0) begin failures++; $display("FAIL mid_setup got=%b exp=0", pc_write); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || pc_write !== 1'b1 || idex_bubble !== 1'b0) begin failures++; $display("FAIL mid_reset got=%b%b%b exp=010", id_valid, pc_write, idex_bubble); end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        drive(I_ADDI, 32'h300, 0, 0, 1, 0);
        advance();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0) begin failures++; $display("FAIL flush_reset got=%b/%h exp=0/0", id_valid, id_inst); end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [6:0]  ops [10];
        logic [31:0] x;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        for (int n = 0; n < 2000; n++) begin
            x = $urandom;
            x[6:0]   = ops[$urandom_range(0, 9)];
            x[19:15] = 5'($urandom_range(0, 3));
            x[24:20] = 5'($urandom_range(0, 3));
            drive(x, 32'(n * 4), ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
            checks++; if (id_inst !== m_inst || id_pc !== m_pc) begin failures++; $display("FAIL rnd_ifid[%0d] got=%h/%h exp=%h/%h", n, id_inst, id_pc, m_inst, m_pc); end
            checks++; if (id_valid !== m_valid) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, id_valid, m_valid); end
            checks++; if (id_opclass !== e_cls) begin failures++; $display("FAIL rnd_cls[%0d] got=%0d exp=%0d", n, id_opclass, e_cls); end
            checks++; if ({pc_write, idex_bubble, pipe_hold} !== {e_pcw, e_bub, e_hold}) begin failures++; $display("FAIL rnd_ctl[%0d] got=%b%b%b exp=%b%b%b", n, pc_write, idex_bubble, pipe_hold, e_pcw, e_bub, e_hold); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_use();
        test_redirect_busy();
        test_busy();
        test_reset_midstall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
